// File: rtl/traffic_ctrl_gen.sv
`default_nettype none
// ============================================================================
// Module   : traffic_ctrl_gen
// Purpose  : Two-road traffic light controller with BCD countdown, pedestrian
//            request and night flashing; macro TRAFFIC_ALL_RED_EN adds AR1/AR2.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_ctrl_gen #(
  parameter int TICK_DIV = 50_000_000,
  parameter int DIGITS   = 2,
  parameter int T_MG     = 60,
  parameter int T_SG     = 20,
  parameter int T_Y      = 4,
  parameter int T_PED    = 5,
  parameter int T_AR     = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                side_req,
  input  logic                ped_req,
  input  logic                night_mode,
  output logic [4*DIGITS-1:0] num,
  output logic [5:0]          led,
  output logic [2:0]          state_o
);

  localparam int NW = 4 * DIGITS;
  localparam int DW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] c_div_last = DW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_MG    = 3'd0,
    S_MY    = 3'd1,
    S_AR1   = 3'd2,
    S_SG    = 3'd3,
    S_SY    = 3'd4,
    S_AR2   = 3'd5,
    S_NIGHT = 3'd6
  } state_t;

  function automatic logic [NW-1:0] to_bcd(input int v);
    logic [NW-1:0] r;
    int            t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  localparam logic [NW-1:0] c_mg  = to_bcd(T_MG);
  localparam logic [NW-1:0] c_sg  = to_bcd(T_SG);
  localparam logic [NW-1:0] c_y   = to_bcd(T_Y);
  localparam logic [NW-1:0] c_ped = to_bcd(T_PED);
  localparam logic [NW-1:0] c_ar  = to_bcd(T_AR);

`ifdef TRAFFIC_ALL_RED_EN
  localparam state_t c_after_my   = S_AR1;
  localparam state_t c_after_sy   = S_AR2;
  localparam state_t c_night_exit = S_AR2;
`else
  localparam state_t c_after_my   = S_SG;
  localparam state_t c_after_sy   = S_MG;
  localparam state_t c_night_exit = S_MG;
`endif

  // Countdown value loaded on entry to a state.
  function automatic logic [NW-1:0] dur(input state_t s);
    case (s)
      S_MG:         return c_mg;
      S_MY, S_SY:   return c_y;
      S_SG:         return c_sg;
      S_AR1, S_AR2: return c_ar;
      default:      return '0;
    endcase
  endfunction

  function automatic logic [NW-1:0] bcd_dec(input logic [NW-1:0] v);
    logic [NW-1:0] r;
    logic          br;
    r  = v;
    br = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (br) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          br          = 1'b0;
        end
      end
    end
    return r;
  endfunction

  state_t        state_q, state_d;
  logic [NW-1:0] num_q, num_d;
  logic [DW-1:0] div_q, div_d;
  logic          ped_q, ped_d;
  logic          blink_q, blink_d;

  logic   tick, ped_pend, num_one, legal, go;
  state_t adv;

  assign tick     = (div_q == c_div_last);
  assign ped_pend = ped_q | ped_req;
  assign num_one  = (num_q == NW'(1));

  always_comb begin
    case (state_q)
      S_MG, S_MY, S_SG, S_SY, S_NIGHT: legal = 1'b1;
`ifdef TRAFFIC_ALL_RED_EN
      S_AR1, S_AR2:                    legal = 1'b1;
`endif
      default:                         legal = 1'b0;
    endcase
  end

  always_comb begin
    div_d   = tick ? '0 : div_q + 1'b1;
    state_d = state_q;
    num_d   = num_q;
    blink_d = blink_q;
    ped_d   = ped_pend;
    go      = 1'b0;
    adv     = state_q;
    if (!legal) begin
      // Corrupted state code: recover immediately, without waiting for a tick.
      state_d = S_MG;
      num_d   = c_mg;
    end else if (tick) begin
      if (state_q == S_NIGHT) begin
        blink_d = ~blink_q;
        if (!night_mode) begin
          go  = 1'b1;
          adv = c_night_exit;
        end
      end else if (night_mode) begin
        state_d = S_NIGHT;
        num_d   = '0;
      end else begin
        case (state_q)
          S_MG: begin
            if (num_one) begin
              if (side_req || ped_pend) begin
                go  = 1'b1;
                adv = S_MY;
              end else begin
                num_d = c_mg;
              end
            end else if (ped_pend && (num_q > c_ped)) begin
              num_d = c_ped;
            end else begin
              num_d = bcd_dec(num_q);
            end
          end
          S_MY: begin
            if (num_one) begin
              go  = 1'b1;
              adv = c_after_my;
            end else begin
              num_d = bcd_dec(num_q);
            end
          end
          S_SG: begin
            if (!side_req || num_one) begin
              go  = 1'b1;
              adv = S_SY;
            end else begin
              num_d = bcd_dec(num_q);
            end
          end
          S_SY: begin
            if (num_one) begin
              go  = 1'b1;
              adv = c_after_sy;
            end else begin
              num_d = bcd_dec(num_q);
            end
          end
`ifdef TRAFFIC_ALL_RED_EN
          S_AR1: begin
            if (num_one) begin
              go  = 1'b1;
              adv = S_SG;
            end else begin
              num_d = bcd_dec(num_q);
            end
          end
          S_AR2: begin
            if (num_one) begin
              go  = 1'b1;
              adv = S_MG;
            end else begin
              num_d = bcd_dec(num_q);
            end
          end
`endif
          default: ;
        endcase
      end
      if (go) begin
        state_d = adv;
        num_d   = dur(adv);
        if (adv == S_MY) ped_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_MG;
      num_q   <= c_mg;
      div_q   <= '0;
      ped_q   <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      div_q   <= div_d;
      ped_q   <= ped_d;
      blink_q <= blink_d;
    end
  end

  always_comb begin
    led = 6'b100100;
    case (state_q)
      S_MG:         led = 6'b001100;
      S_MY:         led = 6'b010100;
      S_SG:         led = 6'b100001;
      S_SY:         led = 6'b100010;
      S_AR1, S_AR2: led = 6'b100100;
      S_NIGHT:      led = blink_q ? 6'b010010 : 6'b000000;
      default:      led = 6'b100100;
    endcase
  end

  assign num     = num_q;
  assign state_o = state_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_ctrl_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_ctrl_gen
// Purpose  : Self-checking bench for traffic_ctrl_gen (two configurations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_ctrl_gen;

  localparam int MG = 0, MY = 1, AR1 = 2, SG = 3, SY = 4, AR2 = 5, NIGHT = 6;

  logic        clk = 1'b0;
  logic        rst_n0, rst_n1, side_req, ped_req, night_mode;
  logic [7:0]  num0;
  logic [11:0] num1;
  logic [5:0]  led0, led1;
  logic [2:0]  st0, st1;
  logic [5:0]  prev_led;

  always #5 clk = ~clk;

  traffic_ctrl_gen #(.TICK_DIV(4), .DIGITS(2), .T_MG(60), .T_SG(20), .T_Y(4),
                     .T_PED(5), .T_AR(2)) dut0 (
    .clk(clk), .rst_n(rst_n0), .side_req(side_req), .ped_req(ped_req),
    .night_mode(night_mode), .num(num0), .led(led0), .state_o(st0));

  traffic_ctrl_gen #(.TICK_DIV(3), .DIGITS(3), .T_MG(120), .T_SG(20), .T_Y(4),
                     .T_PED(5), .T_AR(2)) dut1 (
    .clk(clk), .rst_n(rst_n1), .side_req(side_req), .ped_req(ped_req),
    .night_mode(night_mode), .num(num1), .led(led1), .state_o(st1));

  int p_div[2] = '{4, 3};
  int p_mg[2]  = '{60, 120};
  int p_sg[2]  = '{20, 20};
  int p_y[2]   = '{4, 4};
  int p_ped[2] = '{5, 5};
  int p_ar[2]  = '{2, 2};

  // Reference model: plain integer countdown and state number per unit.
  int m_state[2], m_cnt[2], m_div[2];
  bit m_ped[2], m_blink[2];
  int n_chk = 0, n_fail = 0;

  function automatic int dur_of(int u, int s);
    int r;
    case (s)
      MG:       r = p_mg[u];
      MY, SY:   r = p_y[u];
      SG:       r = p_sg[u];
      AR1, AR2: r = p_ar[u];
      default:  r = 0;
    endcase
    return r;
  endfunction

  function automatic int succ(int s);
    int r;
    case (s)
`ifdef TRAFFIC_ALL_RED_EN
      MG: r = MY;  MY: r = AR1; AR1: r = SG; SG: r = SY; SY: r = AR2; AR2: r = MG;
      NIGHT: r = AR2;
`else
      MG: r = MY;  MY: r = SG;  SG: r = SY;  SY: r = MG;
      NIGHT: r = MG;
`endif
      default: r = MG;
    endcase
    return r;
  endfunction

  function automatic logic [5:0] led_of(int s, bit b);
    logic [5:0] r;
    case (s)
      MG:       r = 6'b001100;
      MY:       r = 6'b010100;
      SG:       r = 6'b100001;
      SY:       r = 6'b100010;
      AR1, AR2: r = 6'b100100;
      NIGHT:    r = b ? 6'b010010 : 6'b000000;
      default:  r = 6'bxxxxxx;
    endcase
    return r;
  endfunction

  function automatic logic [11:0] bcd(int v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic enter(int u, int d);
    m_state[u] = d;
    m_cnt[u]   = dur_of(u, d);
    if (d == MY) m_ped[u] = 1'b0;
  endtask

  task automatic model_step(int u, logic rn);
    bit tick;
    int s;
    if (!rn) begin
      m_state[u] = MG; m_cnt[u] = p_mg[u]; m_div[u] = 0;
      m_ped[u] = 1'b0; m_blink[u] = 1'b0;
      return;
    end
    tick     = (m_div[u] == p_div[u] - 1);
    m_div[u] = tick ? 0 : m_div[u] + 1;
    m_ped[u] = m_ped[u] || ped_req;
    if (!tick) return;
    s = m_state[u];
    if (s == NIGHT) begin
      m_blink[u] = !m_blink[u];
      if (!night_mode) enter(u, succ(NIGHT));
    end else if (night_mode) begin
      m_state[u] = NIGHT;
      m_cnt[u]   = 0;
    end else if (s == SG && !side_req) begin
      enter(u, SY);
    end else if (m_cnt[u] == 1) begin
      if (s == MG && !(side_req || m_ped[u])) m_cnt[u] = p_mg[u];
      else enter(u, succ(s));
    end else if (s == MG && m_ped[u] && m_cnt[u] > p_ped[u]) begin
      m_cnt[u] = p_ped[u];
    end else begin
      m_cnt[u] = m_cnt[u] - 1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock: advance the model with the inputs the DUT will sample, then compare.
  task automatic cyc();
    model_step(0, rst_n0);
    model_step(1, rst_n1);
    @(negedge clk);
    chk("state0", st0,  m_state[0]);
    chk("num0",   num0, bcd(m_cnt[0]));
    chk("led0",   led0, led_of(m_state[0], m_blink[0]));
    chk("state1", st1,  m_state[1]);
    chk("num1",   num1, bcd(m_cnt[1]));
    chk("led1",   led1, led_of(m_state[1], m_blink[1]));
  endtask

  task automatic wait_for(int u, int s, int c, int budget, input string name);
    int k = 0;
    while (!(m_state[u] == s && m_cnt[u] == c) && k < budget) begin
      cyc();
      k++;
    end
    n_chk++;
    if (!(m_state[u] == s && m_cnt[u] == c)) begin
      n_fail++;
      $display("FAIL %s: timeout, state %0d cnt %0d wanted state %0d cnt %0d",
               name, m_state[u], m_cnt[u], s, c);
    end
  endtask

  initial begin
    rst_n0 = 1'b0; rst_n1 = 1'b0;
    side_req = 1'b0; ped_req = 1'b0; night_mode = 1'b0;
    repeat (3) cyc();
    chk("rst_num0",   num0, 8'h60);
    chk("rst_led0",   led0, 6'b001100);
    chk("rst_state0", st0,  3'd0);
    chk("rst_num1",   num1, 12'h120);

    // First tick lands TICK_DIV cycles after release.
    rst_n0 = 1'b1; rst_n1 = 1'b1;
    repeat (3) cyc();
    chk("pre_tick_num0", num0, 8'h60);
    cyc();
    chk("first_tick_num0", num0, 8'h59);

    // Three-digit unit: reset mid-count, then 100 -> 099 borrow.
    wait_for(1, MG, 100, 200, "u1_at_100");
    rst_n1 = 1'b0;
    cyc();
    chk("u1_rst_num",   num1, 12'h120);
    chk("u1_rst_state", st1,  3'd0);
    chk("u1_rst_led",   led1, 6'b001100);
    rst_n1 = 1'b1;
    wait_for(1, MG, 100, 200, "u1_at_100b");
    wait_for(1, MG, 99, 4, "u1_at_099");
    chk("u1_borrow", num1, 12'h099);

    // No side traffic: 10 -> 09, and 01 reloads 60 in MG.
    wait_for(0, MG, 10, 400, "mg_10");
    chk("mg_10", num0, 8'h10);
    wait_for(0, MG, 9, 5, "mg_09");
    chk("mg_09", num0, 8'h09);
    wait_for(0, MG, 1, 100, "mg_01");
    wait_for(0, MG, 60, 5, "mg_reload");
    chk("mg_reload_num",   num0, 8'h60);
    chk("mg_reload_state", st0,  3'd0);

    // Pedestrian pulse at 45 shortens green to 5 and forces MY.
    wait_for(0, MG, 45, 400, "mg_45");
    ped_req = 1'b1;
    cyc();
    ped_req = 1'b0;
    wait_for(0, MG, 5, 8, "ped_short");
    chk("ped_short", num0, 8'h05);
    wait_for(0, MY, 4, 40, "ped_my");
    chk("ped_my_num",   num0, 8'h04);
    chk("ped_my_state", st0,  3'd1);
    chk("ped_my_led",   led0, 6'b010100);

    // Full cycle with side traffic, including early SG termination.
    side_req = 1'b1;
`ifdef TRAFFIC_ALL_RED_EN
    wait_for(0, AR1, 2, 40, "ar1");
    chk("ar1_num", num0, 8'h02);
    chk("ar1_led", led0, 6'b100100);
`endif
    wait_for(0, SG, 20, 40, "sg_20");
    chk("sg_num", num0, 8'h20);
    chk("sg_led", led0, 6'b100001);
    wait_for(0, SG, 15, 40, "sg_15");
    side_req = 1'b0;
    wait_for(0, SY, 4, 6, "sg_early");
    chk("sg_early_num",   num0, 8'h04);
    chk("sg_early_state", st0,  3'd4);
    chk("sy_led",         led0, 6'b100010);
    side_req = 1'b1;
`ifdef TRAFFIC_ALL_RED_EN
    wait_for(0, AR2, 2, 40, "ar2");
    chk("ar2_num", num0, 8'h02);
`endif
    wait_for(0, MG, 60, 40, "mg_back");
    chk("mg_back_num", num0, 8'h60);
    chk("mg_back_led", led0, 6'b001100);
    wait_for(0, MG, 1, 400, "mg_end");
    wait_for(0, MY, 4, 5, "my_side");
    chk("my_side_num", num0, 8'h04);

    // Night mode from SG, blinking, then exit.
    wait_for(0, SG, 20, 100, "sg_night");
    night_mode = 1'b1;
    wait_for(0, NIGHT, 0, 6, "night_in");
    chk("night_num",   num0, 8'h00);
    chk("night_state", st0,  3'd6);
    prev_led = led0;
    for (int i = 0; i < 3; i++) begin
      repeat (4) cyc();
      chk("night_blink", prev_led ^ led0, 6'b010010);
      prev_led = led0;
    end
    night_mode = 1'b0;
`ifdef TRAFFIC_ALL_RED_EN
    wait_for(0, AR2, 2, 6, "night_out");
    chk("night_out_num", num0, 8'h02);
`else
    wait_for(0, MG, 60, 6, "night_out");
    chk("night_out_num", num0, 8'h60);
`endif

    // Randomised traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) side_req = ~side_req;
      ped_req = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 399) == 0) night_mode = ~night_mode;
      rst_n0 = ($urandom_range(0, 999) != 0);
      rst_n1 = ($urandom_range(0, 999) != 0);
      cyc();
    end
    rst_n0 = 1'b1; rst_n1 = 1'b1; ped_req = 1'b0; night_mode = 1'b0;
    repeat (20) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/traffic_ctrl_gen.md
TRAFFIC_CTRL_GEN -- requirements
Module: traffic_ctrl_gen

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50_000_000, clk cycles per countdown tick (legal values ≥2).
REQ-002 SHALL have parameter DIGITS, default 2, number of BCD digits in num (legal range 1..6).
REQ-003 SHALL have parameter T_MG, default 60, main-green duration in ticks.
REQ-004 SHALL have parameter T_SG, default 20, side-green duration in ticks.
REQ-005 SHALL have parameter T_Y, default 4, yellow duration in ticks (both roads).
REQ-006 SHALL have parameter T_PED, default 5, main-green remainder after a pedestrian request.
REQ-007 SHALL have parameter T_AR, default 2, all-red clearance in ticks.
REQ-008 SHALL restrict every T_* parameter to 1..(10^DIGITS-1); out-of-range values are illegal and behaviour is unspecified.
REQ-009 SHALL have port clk, input, 1, clock.
REQ-010 SHALL have port rst_n, input, 1, reset (asynchronous, active-low).
REQ-011 SHALL have port side_req, input, 1, side-road vehicle present (level, synchronous to clk).
REQ-012 SHALL have port ped_req, input, 1, pedestrian button (single-cycle pulse).
REQ-013 SHALL have port night_mode, input, 1, night flashing request (level).
REQ-014 SHALL have port num, output, 4*DIGITS, BCD remaining ticks, registered.
REQ-015 SHALL have port led, output, 6, {main R,Y,G, side R,Y,G} = led[5:0].
REQ-016 SHALL have port state_o, output, 3, current state code.

Function
REQ-017 SHALL emit an internal tick for one cycle when the divider counter reaches TICK_DIV-1; the counter then wraps to 0.
REQ-018 SHALL use states MG=0, MY=1, AR1=2, SG=3, SY=4, AR2=5, NIGHT=6; codes 7 and any other illegal code SHALL recover to MG with num=T_MG on the next clk.
REQ-019 SHALL drive led from the state as follows: MG=001100, MY=010100, SG=100001, SY=100010, AR1/AR2=100100, NIGHT=010010 when the blink bit is 1 and 000000 otherwise.
REQ-020 SHALL, on a tick with num≠1, decrement num by one in BCD with borrow across all DIGITS (e.g. 0x10 → 0x09, 0x100 → 0x099).
REQ-021 SHALL, on a tick with num==1: MG → MY if side_req or the pedestrian latch is set, else stay in MG and reload T_MG; MY → AR1; AR1 → SG; SG → SY; SY → AR2; AR2 → MG.
REQ-022 SHALL load the duration of the destination state (T_MG, T_Y, T_AR, T_SG) into num in the same cycle as each transition.
REQ-023 SHALL set the pedestrian latch on ped_req in any state and clear it on entry to MY.
REQ-024 SHALL, in MG on a tick with the latch set and num>T_PED (BCD compare), load num=T_PED instead of decrementing.
REQ-025 SHALL, in SG with side_req low on a tick, move to SY with num=T_Y (early termination).
REQ-026 SHALL enter NIGHT from any state on the tick on which night_mode is high, with num=0; in NIGHT the blink bit toggles on every tick.
REQ-027 SHALL leave NIGHT on the tick on which night_mode is low, going to AR2 with num=T_AR; night_mode takes priority over every other transition.
REQ-028 SHALL change state and num only on ticks, except for the recovery in REQ-018.

Reset
REQ-029 SHALL, when rst_n is low, force state=MG, num=BCD(T_MG), led=001100, divider=0, pedestrian latch=0, blink bit=0, and hold these values until the release edge.
REQ-030 SHALL produce the first tick TICK_DIV cycles after reset release; a reset asserted mid-countdown discards all progress.

Configuration
REQ-031 SHALL, with macro TRAFFIC_ALL_RED_EN defined, include AR1 and AR2 as specified above.
REQ-032 SHALL, without TRAFFIC_ALL_RED_EN, omit AR1 and AR2: MY → SG, SY → MG, and NIGHT exit goes to MG with num=T_MG; T_AR is then unused.

Verification
REQ-033 SHALL cover: TICK_DIV=4, DIGITS=2, side_req=1 → MG counts 0x60…0x01, then MY with 0x04, AR1 0x02, SG 0x20, SY 0x04, AR2 0x02, MG 0x60.
REQ-034 SHALL cover: side_req=0 throughout → num goes 0x01 → 0x60, state stays MG, and 0x10 decrements to 0x09.
REQ-035 SHALL cover: ped_req pulse while num=0x45 in MG → next tick num=0x05, and MY is entered after 0x01 even with side_req=0.
REQ-036 SHALL cover: side_req dropped while SG num=0x15 → next tick SY with num=0x04.
REQ-037 SHALL cover: night_mode=1 in SG → next tick NIGHT with led alternating 010010/000000 each tick; night_mode=0 → AR2 with num=0x02.
REQ-038 SHALL cover: DIGITS=3, T_MG=120, rst_n pulsed low at num=0x100 → num=0x120, state MG, led=001100, and 0x100 → 0x099 on a later run.
